api_spi_responder: RTL and testbench

- Chip-side end of the API serial link: the SPI slave that the API master block drives via load/sck/mosi/miso.
- Shifts in work frames of WORK_LEN 32-bit words, MSB first, and presents each word on a parallel output.
- Shifts out buffered nonce results on miso during the same frame.
- Used in the miner-side RTL and as the bench responder model for the API master.

---
 rtl/api_spi_responder_pkg.sv | 11 +
 rtl/api_sfifo.sv | 47 ++++
 rtl/api_spi_responder.sv | 161 ++++++++++++++++
 tb/tb_api_spi_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/api_spi_responder_pkg.sv
// Shared definitions for the API serial link responder: word width, idle fill word
// and FSM state encoding.
package api_spi_responder_pkg;
  localparam int API_WORD_W = 32;
  localparam logic [API_WORD_W-1:0] IDLE_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } api_state_e;
endpackage

// File: rtl/api_sfifo.sv
// Parameterized synchronous FIFO; a pop frees a slot for a push in the same cycle.
module api_sfifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
endmodule

// File: rtl/api_spi_responder.sv
// SPI slave end of the API link: receives work frames on mosi and streams
// buffered nonces (or the idle word) back on miso within the same frame.
module api_spi_responder
  import api_spi_responder_pkg::*;
#(
  parameter  int                    WORK_LEN    = 23,
  parameter  int                    NONCE_DEPTH = 16,
  parameter  logic [API_WORD_W-1:0] IDLE_WORD   = IDLE_WORD_DEF,
  localparam int                    CW          = $clog2(NONCE_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  work_valid,
  output logic [API_WORD_W-1:0] work_data,
  output logic [4:0]            work_idx,
  output logic                  work_done,
  output logic                  frame_err,
  input  logic                  nonce_push,
  input  logic [API_WORD_W-1:0] nonce_din,
  output logic                  nonce_full,
  output logic [CW-1:0]         nonce_cnt
);
  localparam int              WCW   = $clog2(WORK_LEN + 2);
  localparam logic [WCW-1:0]  W_LEN = WCW'(WORK_LEN);
  localparam logic [WCW-1:0]  W_SAT = WCW'(WORK_LEN + 1);

  api_state_e            state, state_n;
  logic                  load_meta, load_s, load_d;
  logic                  sck_meta, sck_s, sck_d;
  logic                  mosi_meta, mosi_s;
  logic                  load_rise, load_fall, sck_rise, sck_fall;
  logic [API_WORD_W-1:0] rx_sr, tx_sr;
  logic [4:0]            bit_cnt;
  logic [WCW-1:0]        word_cnt;
  logic                  wv_pend;
  logic [4:0]            idx_pend;
  logic                  start, finish, rx_step, tx_load, tx_shift;
  logic                  fifo_empty;
  logic [API_WORD_W-1:0] fifo_dout;

  // load resets high so a frame already running at reset release never looks like a rise
  always_ff @(posedge clk) begin
    if (rst) begin
      {load_meta, load_s, load_d} <= 3'b111;
      {sck_meta, sck_s, sck_d}    <= 3'b000;
      {mosi_meta, mosi_s}         <= 2'b00;
    end else begin
      {load_meta, load_s, load_d} <= {load, load_meta, load_s};
      {sck_meta, sck_s, sck_d}    <= {sck, sck_meta, sck_s};
      {mosi_meta, mosi_s}         <= {mosi, mosi_meta};
    end
  end

  assign load_rise = load_s & ~load_d;
  assign load_fall = ~load_s & load_d;
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // load fall takes priority: any sck edge in the same cycle is dropped
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    finish   = 1'b0;
    rx_step  = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_rise) begin
          state_n = ST_SHIFT;
          start   = 1'b1;
          tx_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (load_fall) begin
          state_n = ST_IDLE;
          finish  = 1'b1;
        end else begin
          rx_step = sck_rise;
          if (sck_fall) begin
            if (bit_cnt == 5'd0) tx_load  = 1'b1;
            else                 tx_shift = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miso       <= 1'b0;
      work_valid <= 1'b0;
      work_data  <= '0;
      work_idx   <= '0;
      work_done  <= 1'b0;
      frame_err  <= 1'b0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      wv_pend    <= 1'b0;
      idx_pend   <= '0;
    end else begin
      work_valid <= wv_pend;
      wv_pend    <= 1'b0;
      work_done  <= 1'b0;
      frame_err  <= 1'b0;
      miso       <= (state == ST_SHIFT) & tx_sr[API_WORD_W-1];
      // completed word is staged one cycle so it is presented from rx_sr itself
      if (wv_pend) begin
        work_data <= rx_sr;
        work_idx  <= idx_pend;
      end
      if (tx_load)       tx_sr <= fifo_empty ? IDLE_WORD : fifo_dout;
      else if (tx_shift) tx_sr <= {tx_sr[API_WORD_W-2:0], 1'b0};
      if (start) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end
      if (rx_step) begin
        rx_sr   <= {rx_sr[API_WORD_W-2:0], mosi_s};
        bit_cnt <= bit_cnt + 5'd1;
        if (bit_cnt == 5'd31) begin
          wv_pend  <= (word_cnt < W_LEN);
          idx_pend <= 5'(word_cnt);
          if (word_cnt != W_SAT) word_cnt <= word_cnt + 1'b1;
        end
      end
      if (finish) begin
        if ((word_cnt == W_LEN) && (bit_cnt == 5'd0)) work_done <= 1'b1;
        else                                          frame_err <= 1'b1;
      end
    end
  end

  api_sfifo #(
    .W     (API_WORD_W),
    .DEPTH (NONCE_DEPTH)
  ) u_nonce_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (nonce_push),
    .din   (nonce_din),
    .pop   (tx_load & ~fifo_empty),
    .dout  (fifo_dout),
    .full  (nonce_full),
    .empty (fifo_empty),
    .count (nonce_cnt)
  );
endmodule

// File: tb/tb_api_spi_responder.sv
// Bench for api_spi_responder: SPI master driven at f_clk/8 against a queue-based
// model of the work stream and the nonce FIFO.
module tb_api_spi_responder;
  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, sck = 1'b0, mosi = 1'b0;
  logic        nonce_push = 1'b0;
  logic [31:0] nonce_din = '0;
  logic        miso, work_valid, work_done, frame_err, nonce_full;
  logic [31:0] work_data;
  logic [4:0]  work_idx, nonce_cnt;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] tx_words [32];
  logic [31:0] got_miso [32];
  logic [31:0] exp_miso [33];
  logic [31:0] mq [$];
  logic [4:0]  vq_idx [$];
  logic [31:0] vq_data [$];
  int          done_total = 0, err_total = 0;
  int          snap_v = 0, snap_d = 0, snap_e = 0;

  api_spi_responder dut (
    .clk(clk), .rst(rst), .load(load), .sck(sck), .mosi(mosi), .miso(miso),
    .work_valid(work_valid), .work_data(work_data), .work_idx(work_idx),
    .work_done(work_done), .frame_err(frame_err), .nonce_push(nonce_push),
    .nonce_din(nonce_din), .nonce_full(nonce_full), .nonce_cnt(nonce_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (work_valid) begin
      vq_idx.push_back(work_idx);
      vq_data.push_back(work_data);
    end
    if (work_done) done_total++;
    if (frame_err) err_total++;
  end

  task automatic push_word(input logic [31:0] v);
    @(negedge clk);
    nonce_push = 1'b1;
    nonce_din  = v;
    @(negedge clk);
    nonce_push = 1'b0;
    if (mq.size() < 16) mq.push_back(v);
  endtask

  // Every load rise and every completed word boundary takes one word off the buffer.
  task automatic send_frame(input int nwhole, input int pbits, input int rst_word);
    for (int w = 0; w <= nwhole; w++)
      exp_miso[w] = (mq.size() > 0) ? mq.pop_front() : 32'hFFFF_FFFF;
    @(negedge clk);
    load = 1'b1;
    repeat (8) @(negedge clk);
    for (int w = 0; w < nwhole + ((pbits > 0) ? 1 : 0); w++) begin
      int nb;
      nb = (w < nwhole) ? 32 : pbits;
      got_miso[w] = '0;
      for (int b = 0; b < nb; b++) begin
        if (w == rst_word && b == 10) begin
          rst = 1'b1;
          repeat (3) @(negedge clk);
          rst = 1'b0;
          mq.delete();
          snap_v = vq_idx.size();
          snap_d = done_total;
          snap_e = err_total;
        end
        mosi = tx_words[w][31-b];
        repeat (4) @(negedge clk);
        got_miso[w][31-b] = miso;
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({miso, work_valid, work_done, frame_err, nonce_full} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b exp 00000", {miso, work_valid, work_done, frame_err, nonce_full});
    end
    n_cmp++;
    if (work_data !== 32'h0 || work_idx !== 5'd0 || nonce_cnt !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_values data %h idx %0d cnt %0d exp 0", work_data, work_idx, nonce_cnt);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (vq_idx.size() !== 0 || done_total !== 0 || err_total !== 0 || miso !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle valid %0d done %0d err %0d miso %b exp 0", vq_idx.size(), done_total, err_total, miso);
    end
  endtask

  task automatic test_frames();
    int nw [6] = '{23, 23, 22, 24, 5, 23};
    int pb [6] = '{0, 0, 0, 0, 10, 0};
    int np [6] = '{0, 2, 0, 0, 0, 17};
    for (int i = 0; i < 8; i++) begin
      int w, p, n, s_v, s_d, s_e, exp_n;
      bit done_exp;
      if (i < 6) begin
        w = nw[i]; p = pb[i]; n = np[i];
      end else begin
        w = $urandom_range(25, 1);
        p = ($urandom_range(2, 0) == 0) ? $urandom_range(31, 1) : 0;
        n = $urandom_range(6, 0);
      end
      for (int k = 0; k < n; k++)
        push_word((i == 1) ? ((k == 0) ? 32'hDEAD_BEEF : 32'h1234_5678) : $urandom);
      n_cmp++;
      if (nonce_cnt !== 5'(mq.size()) || nonce_full !== (mq.size() == 16)) begin
        n_bad++;
        $display("FAIL f%0d pre_fifo cnt %0d full %b exp cnt %0d full %b", i, nonce_cnt, nonce_full, mq.size(), mq.size() == 16);
      end
      for (int k = 0; k < 32; k++) tx_words[k] = (i == 0) ? 32'(k) : $urandom;
      s_v = vq_idx.size(); s_d = done_total; s_e = err_total;
      send_frame(w, p, -1);
      exp_n    = (w < 23) ? w : 23;
      done_exp = (w == 23) && (p == 0);
      n_cmp++;
      if (vq_idx.size() - s_v !== exp_n) begin
        n_bad++;
        $display("FAIL f%0d valid_count got %0d exp %0d", i, vq_idx.size() - s_v, exp_n);
      end
      for (int k = 0; k < exp_n && s_v + k < vq_idx.size(); k++) begin
        n_cmp++;
        if (vq_idx[s_v+k] !== 5'(k) || vq_data[s_v+k] !== tx_words[k]) begin
          n_bad++;
          $display("FAIL f%0d work[%0d] got idx %0d data %h exp idx %0d data %h", i, k, vq_idx[s_v+k], vq_data[s_v+k], k, tx_words[k]);
        end
      end
      n_cmp++;
      if (done_total - s_d !== int'(done_exp) || err_total - s_e !== int'(!done_exp)) begin
        n_bad++;
        $display("FAIL f%0d end_pulses got done %0d err %0d exp done %0d err %0d", i, done_total - s_d, err_total - s_e, done_exp, !done_exp);
      end
      for (int k = 0; k < w && k < 32; k++) begin
        n_cmp++;
        if (got_miso[k] !== exp_miso[k]) begin
          n_bad++;
          $display("FAIL f%0d miso[%0d] got %h exp %h", i, k, got_miso[k], exp_miso[k]);
        end
      end
      n_cmp++;
      if (nonce_cnt !== 5'(mq.size())) begin
        n_bad++;
        $display("FAIL f%0d post_cnt got %0d exp %0d", i, nonce_cnt, mq.size());
      end
    end
  endtask

  task automatic test_reset_midframe();
    int s_v, s_d, s_e;
    for (int k = 0; k < 3; k++) push_word($urandom);
    for (int k = 0; k < 32; k++) tx_words[k] = $urandom;
    s_v = vq_idx.size(); s_d = done_total; s_e = err_total;
    send_frame(9, 0, 7);
    n_cmp++;
    if (snap_v - s_v !== 7) begin
      n_bad++;
      $display("FAIL rst_pre_words got %0d exp 7", snap_v - s_v);
    end
    n_cmp++;
    if (vq_idx.size() !== snap_v || done_total !== snap_d || err_total !== snap_e) begin
      n_bad++;
      $display("FAIL rst_post_pulses valid %0d done %0d err %0d exp 0", vq_idx.size() - snap_v, done_total - snap_d, err_total - snap_e);
    end
    n_cmp++;
    if (nonce_cnt !== 5'd0 || s_d !== done_total || s_e !== err_total) begin
      n_bad++;
      $display("FAIL rst_cleared cnt %0d exp 0", nonce_cnt);
    end
    for (int k = 0; k < 32; k++) tx_words[k] = $urandom;
    s_v = vq_idx.size(); s_d = done_total; s_e = err_total;
    send_frame(23, 0, -1);
    n_cmp++;
    if (vq_idx.size() - s_v !== 23 || done_total - s_d !== 1 || err_total - s_e !== 0) begin
      n_bad++;
      $display("FAIL rst_next_frame valid %0d done %0d err %0d exp 23/1/0", vq_idx.size() - s_v, done_total - s_d, err_total - s_e);
    end
    for (int k = 0; k < 23 && s_v + k < vq_idx.size(); k++) begin
      n_cmp++;
      if (vq_idx[s_v+k] !== 5'(k) || vq_data[s_v+k] !== tx_words[k]) begin
        n_bad++;
        $display("FAIL rst_next work[%0d] got %0d/%h exp %0d/%h", k, vq_idx[s_v+k], vq_data[s_v+k], k, tx_words[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
